// File: rtl/uart_echo_engine.sv
// uart_echo_engine
//   Glue between the uart core's FIFO-side handshake and the rx/tx pins.
//   It pops bytes from the receive FIFO, adds OFFSET and pushes the result to
//   the transmit FIFO. Transfers are either stepped by hand or automatic.
//   Mode 10 bypasses the core and loops the rx pin straight back to tx.
//   It also keeps last-byte registers, saturating statistics counters and
//   registered pin monitors.
//
// Ports
//   clk, reset            system clock, async active-high reset
//   mode[1:0]             00 manual step, 01 auto echo, 10 pin loopback, 11 off
//   step                  one-cycle pulse, used in manual mode only
//   rx, tx_core           synchronised rx pin, serial output of uart core
//   rx_empty, r_data      receive FIFO status and head (first-word fall-through)
//   tx_full               transmit FIFO full
//   rd_uart, wr_uart      receive-pop / transmit-push strobes (registered)
//   w_data                byte pushed, held between pushes
//   tx, rx_monitor, tx_monitor   registered pin outputs
//   last_rx, last_tx      last byte popped / pushed
//   rx_count, tx_count, drop_count   saturating statistics
//   busy                  FSM not in IDLE
module uart_echo_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int OFFSET     = 1,
    parameter int TX_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic                  step,
    input  logic                  rx,
    input  logic                  tx_core,
    input  logic                  rx_empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic                  tx_full,
    output logic                  rd_uart,
    output logic                  wr_uart,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  tx,
    output logic                  rx_monitor,
    output logic                  tx_monitor,
    output logic [DATA_WIDTH-1:0] last_rx,
    output logic [DATA_WIDTH-1:0] last_tx,
    output logic [CNT_WIDTH-1:0]  rx_count,
    output logic [CNT_WIDTH-1:0]  tx_count,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic                  busy
);
    localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [TW-1:0]         TMO_LAST = TW'(TX_TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] OFF_W    = DATA_WIDTH'(OFFSET);

    typedef enum logic {IDLE, PUSH} state_t;

    state_t                state_q;
    logic                  rd_q, wr_q;
    logic [DATA_WIDTH-1:0] hold_q, w_data_q, last_rx_q, last_tx_q;
    logic [CNT_WIDTH-1:0]  rx_cnt_q, tx_cnt_q, drop_cnt_q;
    logic [TW-1:0]         tmo_q;
    logic                  tx_q, rxm_q, txm_q;

    logic                  trigger_d;
    logic [DATA_WIDTH-1:0] hold_d;

    // A step pulse seen while the FIFO is empty is simply lost.
    assign trigger_d = !rx_empty && ((mode == 2'b01) || ((mode == 2'b00) && step));
    assign hold_d    = r_data + OFF_W;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Strobes are registered. The pop pulse shows in the first PUSH cycle
    // and the push pulse in the following IDLE cycle, so the two never
    // overlap and pops are at least two cycles apart. The mode input is
    // only sampled in IDLE, so a held byte always finishes first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            hold_q     <= '0;
            w_data_q   <= '0;
            last_rx_q  <= '0;
            last_tx_q  <= '0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            drop_cnt_q <= '0;
            tmo_q      <= '0;
        end else begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trigger_d) begin
                        rd_q      <= 1'b1;
                        last_rx_q <= r_data;
                        hold_q    <= hold_d;
                        rx_cnt_q  <= sat_inc(rx_cnt_q);
                        tmo_q     <= '0;
                        state_q   <= PUSH;
                    end
                end
                PUSH: begin
                    if (!tx_full) begin
                        wr_q      <= 1'b1;
                        w_data_q  <= hold_q;
                        last_tx_q <= hold_q;
                        tx_cnt_q  <= sat_inc(tx_cnt_q);
                        state_q   <= IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        drop_cnt_q <= sat_inc(drop_cnt_q);
                        state_q    <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pin path: reset to line-idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_q  <= 1'b1;
            rxm_q <= 1'b1;
            txm_q <= 1'b1;
        end else begin
            tx_q  <= (mode == 2'b10) ? rx : tx_core;
            rxm_q <= rx;
            txm_q <= tx_q;
        end
    end

    assign rd_uart    = rd_q;
    assign wr_uart    = wr_q;
    assign w_data     = w_data_q;
    assign last_rx    = last_rx_q;
    assign last_tx    = last_tx_q;
    assign rx_count   = rx_cnt_q;
    assign tx_count   = tx_cnt_q;
    assign drop_count = drop_cnt_q;
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;
    assign rx_monitor = rxm_q;
    assign tx_monitor = txm_q;
endmodule

// File: tb/tb_uart_echo_engine.sv
// Directed bench for uart_echo_engine. The main instance uses TX_TIMEOUT=4.
// A second instance uses CNT_WIDTH=4 and TX_TIMEOUT=1; its counters
// saturate within a short run.
module tb_uart_echo_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mode = 2'b11;
    logic        step = 1'b0, rx = 1'b1, tx_core = 1'b1, tx_full = 1'b0;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart, wr_uart, tx, rx_monitor, tx_monitor, busy;
    logic [7:0]  w_data, last_rx, last_tx;
    logic [15:0] rx_count, tx_count, drop_count;

    logic [1:0]  mode2 = 2'b11;
    logic        tx_full2 = 1'b0;
    logic        rd2, wr2, tx2, rxm2, txm2, busy2;
    logic [7:0]  w_data2, last_rx2, last_tx2;
    logic [3:0]  rx_cnt2, tx_cnt2, drop_cnt2;
    logic [7:0]  r_data2 = 8'hA5;
    logic        rx_empty2 = 1'b0;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    uart_echo_engine #(.DATA_WIDTH(8), .CNT_WIDTH(16), .OFFSET(1), .TX_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .mode(mode), .step(step), .rx(rx), .tx_core(tx_core),
        .rx_empty(rx_empty), .r_data(r_data), .tx_full(tx_full),
        .rd_uart(rd_uart), .wr_uart(wr_uart), .w_data(w_data), .tx(tx),
        .rx_monitor(rx_monitor), .tx_monitor(tx_monitor), .last_rx(last_rx), .last_tx(last_tx),
        .rx_count(rx_count), .tx_count(tx_count), .drop_count(drop_count), .busy(busy));

    uart_echo_engine #(.DATA_WIDTH(8), .CNT_WIDTH(4), .OFFSET(1), .TX_TIMEOUT(1)) dut2 (
        .clk(clk), .reset(reset), .mode(mode2), .step(1'b0), .rx(1'b1), .tx_core(1'b1),
        .rx_empty(rx_empty2), .r_data(r_data2), .tx_full(tx_full2),
        .rd_uart(rd2), .wr_uart(wr2), .w_data(w_data2), .tx(tx2),
        .rx_monitor(rxm2), .tx_monitor(txm2), .last_rx(last_rx2), .last_tx(last_tx2),
        .rx_count(rx_cnt2), .tx_count(tx_cnt2), .drop_count(drop_cnt2), .busy(busy2));

    // Receive FIFO model (first-word fall-through)
    logic [7:0] fmem [0:15];
    int fhead = 0, ftail = 0;
    assign rx_empty = (fhead == ftail);
    assign r_data   = fmem[fhead[3:0]];
    always @(posedge clk) if (rd_uart && fhead != ftail) fhead <= fhead + 1;

    task automatic fpush(input logic [7:0] b);
        fmem[ftail[3:0]] = b;
        ftail = ftail + 1;
    endtask

    // Strobe monitor: push log, strobe counts, handshake rule violations
    int cyc = 0, rd_n = 0, wr_n = 0, viol = 0, gap_bad = 0, last_rd_cyc = 0;
    logic prev_rd = 1'b0;
    logic [7:0] wlog [0:63];
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_rd <= rd_uart;
        if (rd_uart) begin
            rd_n        <= rd_n + 1;
            last_rd_cyc <= cyc;
        end
        if (wr_uart) begin
            wlog[wr_n[5:0]] <= w_data;
            wr_n            <= wr_n + 1;
            if (cyc - last_rd_cyc != 1) gap_bad <= gap_bad + 1;
        end
        if ((rd_uart && wr_uart) || (rd_uart && prev_rd)) viol <= viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base_rd, base_wr, base_gap, k;

        // ---- reset values
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rd",    32'(rd_uart), 32'd0);
        check("rst_wr",    32'(wr_uart), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_wdata", 32'(w_data), 32'd0);
        check("rst_lastrx", 32'(last_rx), 32'd0);
        check("rst_cnts",  {rx_count, tx_count} | 32'(drop_count), 32'd0);
        check("rst_pins",  {29'd0, tx, rx_monitor, tx_monitor}, 32'd7);

        // ---- reset while holding a byte in PUSH with tx_full high
        reset = 1'b0; tx_full = 1'b1; mode = 2'b01; fpush(8'h55);
        @(negedge clk);
        check("a_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("a_rst_busy", 32'(busy), 32'd0);
        check("a_rst_strb", {30'd0, rd_uart, wr_uart}, 32'd0);
        check("a_rst_rxc",  32'(rx_count), 32'd0);
        check("a_rst_lrx",  32'(last_rx), 32'd0);
        @(negedge clk);
        mode = 2'b11; tx_full = 1'b0; reset = 1'b0;
        repeat (10) @(negedge clk);
        check("a_no_wr",  32'(wr_n), 32'd0);
        check("a_txc",    32'(tx_count), 32'd0);

        // ---- auto echo of three bytes
        base_wr = wr_n; base_gap = gap_bad;
        mode = 2'b01; fpush(8'h41); fpush(8'h7F); fpush(8'hFF);
        for (k = 0; k < 50 && wr_n != base_wr + 3; k++) @(negedge clk);
        check("b_npush", 32'(wr_n - base_wr), 32'd3);
        check("b_w0", 32'(wlog[6'(base_wr)]),     32'h42);
        check("b_w1", 32'(wlog[6'(base_wr + 1)]), 32'h80);
        check("b_w2", 32'(wlog[6'(base_wr + 2)]), 32'h00);
        check("b_rxc", 32'(rx_count), 32'd3);
        check("b_txc", 32'(tx_count), 32'd3);
        check("b_ltx", 32'(last_tx), 32'h00);
        check("b_lrx", 32'(last_rx), 32'hFF);
        check("b_gap", 32'(gap_bad - base_gap), 32'd0);

        // ---- manual step
        mode = 2'b00; fpush(8'h10);
        base_rd = rd_n;
        repeat (100) @(negedge clk);
        check("c_nostep_rd", 32'(rd_n - base_rd), 32'd0);
        check("c_nostep_busy", 32'(busy), 32'd0);
        step = 1'b1; @(negedge clk); step = 1'b0;
        repeat (5) @(negedge clk);
        check("c_step_rd", 32'(rd_n - base_rd), 32'd1);
        check("c_wdata", 32'(w_data), 32'h11);
        check("c_lrx",   32'(last_rx), 32'h10);
        check("c_rxc",   32'(rx_count), 32'd4);
        base_rd = rd_n; base_wr = wr_n;
        step = 1'b1; @(negedge clk); step = 1'b0;
        repeat (5) @(negedge clk);
        check("c_empty_strb", 32'((rd_n - base_rd) + (wr_n - base_wr)), 32'd0);
        check("c_empty_cnt",  {rx_count, tx_count}, {16'd4, 16'd4});

        // ---- transmit timeout drop, TX_TIMEOUT=4
        mode = 2'b01; tx_full = 1'b1; fpush(8'h20);
        base_wr = wr_n;
        for (k = 0; k < 20 && !busy; k++) @(negedge clk);
        check("d_enter", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        check("d_drop_early", 32'(drop_count), 32'd0);
        check("d_busy_early", 32'(busy), 32'd1);
        @(negedge clk);
        check("d_drop", 32'(drop_count), 32'd1);
        check("d_idle", 32'(busy), 32'd0);
        check("d_no_wr", 32'(wr_n - base_wr), 32'd0);

        // ---- tx_full high for two PUSH cycles, then low
        fpush(8'h30);
        for (k = 0; k < 20 && !busy; k++) @(negedge clk);
        @(negedge clk);
        check("e_wait_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("e_wait_wr", 32'(wr_uart), 32'd0);
        tx_full = 1'b0;
        @(negedge clk);
        check("e_wr", 32'(wr_uart), 32'd1);
        check("e_wdata", 32'(w_data), 32'h31);
        check("e_drop", 32'(drop_count), 32'd1);

        // ---- raw pin loopback
        base_rd = rd_n;
        mode = 2'b10; fpush(8'h66); rx = 1'b0;
        @(negedge clk);
        check("f_pins1", {29'd0, tx, rx_monitor, tx_monitor}, 32'b001);
        @(negedge clk);
        check("f_txmon0", 32'(tx_monitor), 32'd0);
        rx = 1'b1;
        @(negedge clk);
        check("f_pins3", {29'd0, tx, rx_monitor, tx_monitor}, 32'b110);
        @(negedge clk);
        check("f_txmon1", 32'(tx_monitor), 32'd1);
        repeat (10) @(negedge clk);
        check("f_no_rd", 32'(rd_n - base_rd), 32'd0);
        base_wr = wr_n;
        mode = 2'b01;
        for (k = 0; k < 20 && wr_n == base_wr; k++) @(negedge clk);
        check("f_resume", 32'(wlog[6'(base_wr)]), 32'h67);
        check("f_cnts", {rx_count, tx_count}, {16'd7, 16'd6});
        mode = 2'b11; tx_core = 1'b0;
        @(negedge clk);
        check("f_mode11_tx", 32'(tx), 32'd0);
        tx_core = 1'b1;

        // ---- saturation on the narrow-counter instance
        mode2 = 2'b01; tx_full2 = 1'b0;
        repeat (100) @(negedge clk);
        check("g_rx_sat", 32'(rx_cnt2), 32'd15);
        check("g_tx_sat", 32'(tx_cnt2), 32'd15);
        check("g_wdata",  32'(w_data2), 32'hA6);
        tx_full2 = 1'b1;
        repeat (100) @(negedge clk);
        check("g_drop_sat", 32'(drop_cnt2), 32'd15);
        check("g_tx_hold",  32'(tx_cnt2), 32'd15);

        check("handshake_rules", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
